// File: rtl/ct_f_spsram_pkg.sv
// Shared types and helpers for the parameterised single-port SRAM.
package ct_f_spsram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } init_state_e;

  // Ceiling log2, at least 1 so it is usable as a vector width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ct_f_spsram_param_ram.sv
// One bit-column storage array: synchronous write, asynchronous read.
module fpga_ram #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  localparam int unsigned WORDS = 32'd1 << ADDR_WIDTH;

  // Contents are intentionally not reset.
  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= din_i;
  end

  assign dout_o = mem_q[raddr_i];

endmodule

// File: rtl/ct_f_spsram_param.sv
// Parameterised single-port SRAM with per-bit write mask and optional output stage.
// Define CT_F_SPSRAM_INIT_EN to add a post-reset clear sequencer.
module ct_f_spsram_param
  import ct_f_spsram_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                  CLK,
  input  logic                  RST_B,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WIDTH-1:0]      WEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [WIDTH-1:0]      D,
  output logic [WIDTH-1:0]      Q,
  output logic                  INIT_BUSY
);

  localparam int unsigned AW1 = ADDR_WIDTH + 1;

  logic                  a_in_range_c;
  logic                  user_acc_c;
  logic                  user_wr_c;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [WIDTH-1:0]      bus_din;
  logic [WIDTH-1:0]      bus_bwe;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rd_en_q;
  logic [WIDTH-1:0]      ram_dout;
  logic [WIDTH-1:0]      q_raw_c;

  assign a_in_range_c = ({1'b0, A} < AW1'(DEPTH));
  assign user_acc_c   = ~CEN & ~INIT_BUSY;
  assign user_wr_c    = user_acc_c & ~GWEN & a_in_range_c;

`ifdef CT_F_SPSRAM_INIT_EN
  localparam int unsigned CNT_W = clog2(DEPTH);

  init_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;

  // Clear sweep: one zero write per cycle from address 0 up to DEPTH-1.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else if (state_q == CLEAR) begin
      cnt_q <= CNT_W'(cnt_q + 1'b1);
      if (cnt_q == CNT_W'(DEPTH - 1)) state_q <= READY;
    end
  end

  assign INIT_BUSY = (state_q == CLEAR);
`else
  assign INIT_BUSY = 1'b0;
`endif

  // Shared write bus: the sequencer owns it while busy, the user port otherwise.
  always_comb begin
    bus_we   = user_wr_c;
    bus_addr = A;
    bus_din  = D;
    bus_bwe  = ~WEN;
`ifdef CT_F_SPSRAM_INIT_EN
    if (INIT_BUSY) begin
      bus_we   = 1'b1;
      bus_addr = ADDR_WIDTH'(cnt_q);
      bus_din  = '0;
      bus_bwe  = '1;
    end
`endif
  end

  // Held read address; rd_en_q masks out-of-range and never-accessed reads to zero.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      addr_q  <= '0;
      rd_en_q <= 1'b0;
    end else if (user_acc_c) begin
      addr_q  <= A;
      rd_en_q <= a_in_range_c;
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_col
    fpga_ram #(
      .DATA_WIDTH(1),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_col (
      .clk_i  (CLK),
      .we_i   (bus_we & bus_bwe[i]),
      .waddr_i(bus_addr),
      .raddr_i(addr_q),
      .din_i  (bus_din[i]),
      .dout_o (ram_dout[i])
    );
  end

  assign q_raw_c = rd_en_q ? ram_dout : '0;

  if (OUT_REG != 0) begin : g_oreg
    logic             acc_q;
    logic [WIDTH-1:0] q_out_q;

    // Output stage only loads after a cycle that actually accessed the array.
    always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
        acc_q   <= 1'b0;
        q_out_q <= '0;
      end else begin
        acc_q <= user_acc_c;
        if (acc_q) q_out_q <= q_raw_c;
      end
    end

    assign Q = q_out_q;
  end else begin : g_noreg
    assign Q = q_raw_c;
  end

endmodule

// File: tb/tb_ct_f_spsram_param.sv
// Directed bench for ct_f_spsram_param: default, DEPTH=100 and OUT_REG=1 instances share stimulus.
module tb_ct_f_spsram_param;

  logic        CLK = 1'b0;
  logic        RST_B;
  logic        CEN;
  logic        GWEN;
  logic [15:0] WEN;
  logic [6:0]  A;
  logic [15:0] D;
  logic [15:0] q0, q100, qor;
  logic        busy0, busy100, busyor;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  ct_f_spsram_param u_d0 (
    .CLK(CLK), .RST_B(RST_B), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
    .A(A), .D(D), .Q(q0), .INIT_BUSY(busy0)
  );

  ct_f_spsram_param #(.DEPTH(100)) u_d100 (
    .CLK(CLK), .RST_B(RST_B), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
    .A(A), .D(D), .Q(q100), .INIT_BUSY(busy100)
  );

  ct_f_spsram_param #(.OUT_REG(1)) u_or (
    .CLK(CLK), .RST_B(RST_B), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
    .A(A), .D(D), .Q(qor), .INIT_BUSY(busyor)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic cen, input logic gwen, input logic [15:0] wen,
                        input int a, input logic [15:0] d);
    CEN  = cen;
    GWEN = gwen;
    WEN  = wen;
    A    = 7'(a);
    D    = d;
  endtask

  task automatic test_reset();
    int n;
    RST_B = 1'b0;
    set_in(1'b1, 1'b1, 16'hFFFF, 0, 16'h0000);
    step();
    step();
    n_chk++; if (q0 !== 16'h0000) $display("FAIL reset_q_d0: got %h want 0000", q0); else n_pass++;
    n_chk++; if (qor !== 16'h0000) $display("FAIL reset_q_oreg: got %h want 0000", qor); else n_pass++;
`ifdef CT_F_SPSRAM_INIT_EN
    n_chk++; if (busy0 !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy0); else n_pass++;
    RST_B = 1'b1;
    n = 0;
    while (busy0 === 1'b1 && n < 400) begin step(); n++; end
    n_chk++; if (n !== 128) $display("FAIL reset_clear_len: got %0d want 128", n); else n_pass++;
`else
    n_chk++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0); else n_pass++;
    RST_B = 1'b1;
    step();
    n_chk++; if (busy100 !== 1'b0) $display("FAIL busy_tied_low: got %b want 0", busy100); else n_pass++;
`endif
  endtask

`ifdef CT_F_SPSRAM_INIT_EN
  // Counts busy cycles from RST_B release (at posedge+1) and checks every word reads 0.
  task automatic test_clear_complete(input string tag, input logic wr_during_busy);
    int n, n100, bad_busy, bad0, bad100, bador;
    n = 0; n100 = 0; bad_busy = 0; bad0 = 0; bad100 = 0; bador = 0;
    if (wr_during_busy) set_in(1'b0, 1'b0, 16'h0000, 5, 16'hFFFF);
    while (busy0 === 1'b1 && n < 400) begin
      step();
      n++;
      if (n == 1) set_in(1'b0, 1'b1, 16'hFFFF, 5, 16'h0000);
      if (busy0 === 1'b1 && (q0 !== 16'h0000 || qor !== 16'h0000)) bad_busy++;
      if (n100 == 0 && busy100 !== 1'b1) n100 = n;
    end
    set_in(1'b1, 1'b1, 16'hFFFF, 0, 16'h0000);
    n_chk++; if (n !== 128) $display("FAIL %s_busy_len: got %0d want 128", tag, n); else n_pass++;
    n_chk++; if (n100 !== 100) $display("FAIL %s_busy_len_d100: got %0d want 100", tag, n100); else n_pass++;
    n_chk++; if (bad_busy !== 0) $display("FAIL %s_q_during_busy: got %0d nonzero want 0", tag, bad_busy); else n_pass++;
    for (int a = 0; a < 128; a++) begin
      set_in(1'b0, 1'b1, 16'hFFFF, a, 16'h0000);
      step();
      if (q0 !== 16'h0000) bad0++;
      if (q100 !== 16'h0000) bad100++;
      if (a > 0 && qor !== 16'h0000) bador++;
    end
    set_in(1'b1, 1'b1, 16'hFFFF, 0, 16'h0000);
    step();
    if (qor !== 16'h0000) bador++;
    n_chk++; if (bad0 !== 0) $display("FAIL %s_contents_d0: got %0d nonzero want 0", tag, bad0); else n_pass++;
    n_chk++; if (bad100 !== 0) $display("FAIL %s_contents_d100: got %0d nonzero want 0", tag, bad100); else n_pass++;
    n_chk++; if (bador !== 0) $display("FAIL %s_contents_oreg: got %0d nonzero want 0", tag, bador); else n_pass++;
  endtask

  task automatic test_init();
    RST_B = 1'b0;
    step();
    RST_B = 1'b1;
    test_clear_complete("init", 1'b1);
  endtask

  task automatic test_reset_midsweep();
    for (int a = 0; a < 128; a++) begin
      set_in(1'b0, 1'b0, 16'h0000, a, 16'(a) ^ 16'hC3C3);
      step();
    end
    set_in(1'b1, 1'b1, 16'hFFFF, 0, 16'h0000);
    RST_B = 1'b0;
    step();
    RST_B = 1'b1;
    repeat (50) step();
    n_chk++; if (busy0 !== 1'b1) $display("FAIL mid_busy_at_50: got %b want 1", busy0); else n_pass++;
    RST_B = 1'b0;
    #1;
    n_chk++; if (busy0 !== 1'b1) $display("FAIL mid_busy_in_reset: got %b want 1", busy0); else n_pass++;
    step();
    RST_B = 1'b1;
    test_clear_complete("midsweep", 1'b0);
  endtask
`endif

  task automatic test_write_read();
    set_in(1'b0, 1'b0, 16'h0000, 7, 16'hA5C3); step();
    n_chk++; if (q0 !== 16'hA5C3) $display("FAIL wr_first_d0: got %h want a5c3", q0); else n_pass++;
    n_chk++; if (q100 !== 16'hA5C3) $display("FAIL wr_first_d100: got %h want a5c3", q100); else n_pass++;
    n_chk++; if (qor !== 16'h0000) $display("FAIL wr_oreg_lat: got %h want 0000", qor); else n_pass++;
    set_in(1'b0, 1'b0, 16'h0000, 3, 16'h0F0F); step();
    n_chk++; if (q0 !== 16'h0F0F) $display("FAIL wr3_d0: got %h want 0f0f", q0); else n_pass++;
    n_chk++; if (qor !== 16'hA5C3) $display("FAIL wr7_oreg: got %h want a5c3", qor); else n_pass++;
    set_in(1'b1, 1'b1, 16'hFFFF, 0, 16'h0000); step();
    n_chk++; if (qor !== 16'h0F0F) $display("FAIL wr3_oreg: got %h want 0f0f", qor); else n_pass++;
    set_in(1'b0, 1'b1, 16'hFFFF, 7, 16'h0000); step();
    n_chk++; if (q0 !== 16'hA5C3) $display("FAIL rd7_d0: got %h want a5c3", q0); else n_pass++;
    n_chk++; if (qor !== 16'h0F0F) $display("FAIL rd7_oreg_early: got %h want 0f0f", qor); else n_pass++;
    set_in(1'b1, 1'b1, 16'hFFFF, 0, 16'h0000); step();
    n_chk++; if (qor !== 16'hA5C3) $display("FAIL rd7_oreg: got %h want a5c3", qor); else n_pass++;
  endtask

  task automatic test_bit_mask();
    set_in(1'b0, 1'b0, 16'hFF00, 7, 16'hFFFF); step();
    n_chk++; if (q0 !== 16'hA5FF) $display("FAIL mask_d0: got %h want a5ff", q0); else n_pass++;
    n_chk++; if (q100 !== 16'hA5FF) $display("FAIL mask_d100: got %h want a5ff", q100); else n_pass++;
    set_in(1'b1, 1'b1, 16'hFFFF, 0, 16'h0000); step();
    n_chk++; if (qor !== 16'hA5FF) $display("FAIL mask_oreg: got %h want a5ff", qor); else n_pass++;
    set_in(1'b0, 1'b1, 16'hFFFF, 3, 16'h0000); step();
    n_chk++; if (q0 !== 16'h0F0F) $display("FAIL mask_other_word: got %h want 0f0f", q0); else n_pass++;
    set_in(1'b1, 1'b1, 16'hFFFF, 0, 16'h0000); step();
  endtask

  task automatic test_hold();
    set_in(1'b0, 1'b1, 16'hFFFF, 7, 16'h0000); step();
    set_in(1'b1, 1'b1, 16'hFFFF, 0, 16'h0000); step();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b0, 16'(i) ^ 16'h5A5A, 0, (i % 2 == 0) ? 16'hFFFF : 16'h0000);
      step();
      n_chk++; if (q0 !== 16'hA5FF) $display("FAIL hold_d0[%0d]: got %h want a5ff", i, q0); else n_pass++;
      n_chk++; if (qor !== 16'hA5FF) $display("FAIL hold_oreg[%0d]: got %h want a5ff", i, qor); else n_pass++;
    end
    set_in(1'b1, 1'b1, 16'hFFFF, 0, 16'h0000);
  endtask

  task automatic test_out_of_range();
    set_in(1'b0, 1'b0, 16'h0000, 99, 16'hBEEF); step();
    n_chk++; if (q100 !== 16'hBEEF) $display("FAIL d100_wr99: got %h want beef", q100); else n_pass++;
    set_in(1'b0, 1'b0, 16'h0000, 120, 16'h1234); step();
    n_chk++; if (q100 !== 16'h0000) $display("FAIL d100_wr120: got %h want 0000", q100); else n_pass++;
    n_chk++; if (q0 !== 16'h1234) $display("FAIL d0_wr120: got %h want 1234", q0); else n_pass++;
    set_in(1'b0, 1'b0, 16'h0000, 100, 16'h5555); step();
    n_chk++; if (q100 !== 16'h0000) $display("FAIL d100_wr100: got %h want 0000", q100); else n_pass++;
    set_in(1'b0, 1'b1, 16'hFFFF, 120, 16'h0000); step();
    n_chk++; if (q100 !== 16'h0000) $display("FAIL d100_rd120: got %h want 0000", q100); else n_pass++;
    set_in(1'b0, 1'b1, 16'h0000, 99, 16'hFFFF); step();
    n_chk++; if (q100 !== 16'hBEEF) $display("FAIL d100_rd99: got %h want beef", q100); else n_pass++;
    set_in(1'b0, 1'b1, 16'hFFFF, 99, 16'h0000); step();
    n_chk++; if (q100 !== 16'hBEEF) $display("FAIL d100_rd99_again: got %h want beef", q100); else n_pass++;
    set_in(1'b0, 1'b0, 16'h0000, 127, 16'h1357); step();
    set_in(1'b0, 1'b1, 16'hFFFF, 3, 16'h0000); step();
    set_in(1'b0, 1'b1, 16'hFFFF, 127, 16'h0000); step();
    n_chk++; if (q0 !== 16'h1357) $display("FAIL d0_rd127: got %h want 1357", q0); else n_pass++;
    set_in(1'b1, 1'b1, 16'hFFFF, 0, 16'h0000); step();
    n_chk++; if (qor !== 16'h1357) $display("FAIL oreg_rd127: got %h want 1357", qor); else n_pass++;
  endtask

  initial begin
    RST_B = 1'b0;
    set_in(1'b1, 1'b1, 16'hFFFF, 0, 16'h0000);
    test_reset();
`ifdef CT_F_SPSRAM_INIT_EN
    test_init();
    test_reset_midsweep();
`endif
    test_write_read();
    test_bit_mask();
    test_hold();
    test_out_of_range();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
